// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a byte-addressed, word-wide data memory port.
// Handles RV32I loads and stores, uses read-modify-write for SB/SH, and flags faulting requests.
module mem_access_unit #(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   // Handshake: a request transfers on a posedge where req_valid and req_ready are both high;
   // the response is a single-cycle resp_valid pulse with no back-pressure.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LD     = 3'd1,
      S_ST_WR  = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   state_t      state;
   logic [2:0]  funct3_q;
   logic [31:0] wdata_q;

   logic [32:0] last_byte;
   logic        out_of_range;
   logic        bad_funct3;
   logic        misaligned;
   logic        fault;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign req_ready = (state == S_IDLE);

   // Compare in 33 bits so addresses near 2^32 cannot wrap back into range.
   assign last_byte    = {1'b0, req_addr} + 33'd3;
   assign out_of_range = (last_byte >= 33'(MEM_BYTES));

   always_comb begin
      bad_funct3 = 1'b0;
      if (req_we) begin
         bad_funct3 = (req_funct3[2] == 1'b1) || (req_funct3[1:0] == 2'b11);
      end else begin
         bad_funct3 = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
      end
   end

   assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign fault      = bad_funct3 || misaligned || out_of_range;

   always_comb begin
      load_ext = mem_rdata;
      case (funct3_q)
         3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         3'b100:  load_ext = {24'd0, mem_rdata[7:0]};
         3'b101:  load_ext = {16'd0, mem_rdata[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   assign merged = funct3_q[0] ? {mem_rdata[31:16], wdata_q[15:0]}
                               : {mem_rdata[31:8], wdata_q[7:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         funct3_q   <= 3'd0;
         wdata_q    <= 32'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         mem_ce     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  funct3_q <= req_funct3;
                  wdata_q  <= req_wdata;
                  if (fault) begin
                     resp_valid <= 1'b1;
                     resp_rdata <= 32'd0;
                     resp_err   <= 1'b1;
                     state      <= S_RESP;
                  end else begin
                     mem_ce   <= 1'b1;
                     mem_addr <= req_addr;
                     if (!req_we) begin
                        state <= S_LD;
                     end else if (req_funct3 == 3'b010) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= req_wdata;
                        state     <= S_ST_WR;
                     end else begin
                        state <= S_RMW_RD;
                     end
                  end
               end
            end
            S_LD: begin
               mem_ce     <= 1'b0;
               resp_valid <= 1'b1;
               resp_rdata <= load_ext;
               resp_err   <= 1'b0;
               state      <= S_RESP;
            end
            S_RMW_RD: begin
               mem_we    <= 1'b1;
               mem_wdata <= merged;
               state     <= S_RMW_WR;
            end
            S_ST_WR, S_RMW_WR: begin
               mem_ce     <= 1'b0;
               mem_we     <= 1'b0;
               resp_valid <= 1'b1;
               resp_rdata <= 32'd0;
               resp_err   <= 1'b0;
               state      <= S_RESP;
            end
            S_RESP: begin
               resp_valid <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               mem_ce     <= 1'b0;
               mem_we     <= 1'b0;
               resp_valid <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-array memory, a reference model computed from the
// load/store rules, and directed plus random scenarios.
module tb_mem_access_unit;
   localparam int MEM_BYTES = 1024;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_ce;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks = 0;
   int failures = 0;
   int ce_cycles = 0;
   int we_cycles = 0;
   int resp_pulses = 0;

   logic [7:0]  mem [MEM_BYTES];
   logic [7:0]  model_mem [MEM_BYTES];
   logic [31:0] exp_q [$];

   mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory: combinational read of four bytes from mem_addr, write on posedge
   always_comb begin
      mem_rdata = 32'd0;
      if (mem_addr <= 32'(MEM_BYTES - 4)) begin
         mem_rdata = {mem[mem_addr[9:0] + 10'd3], mem[mem_addr[9:0] + 10'd2],
                      mem[mem_addr[9:0] + 10'd1], mem[mem_addr[9:0]]};
      end
   end

   always @(posedge clk) begin
      if (mem_ce) ce_cycles++;
      if (mem_we) we_cycles++;
      if (resp_valid) resp_pulses++;
      if (mem_ce && mem_we && mem_addr <= 32'(MEM_BYTES - 4)) begin
         mem[mem_addr[9:0]]         = mem_wdata[7:0];
         mem[mem_addr[9:0] + 10'd1] = mem_wdata[15:8];
         mem[mem_addr[9:0] + 10'd2] = mem_wdata[23:16];
         mem[mem_addr[9:0] + 10'd3] = mem_wdata[31:24];
      end
   end

   // reference model
   function automatic int access_size(input logic we, input logic [2:0] f3);
      int s;
      case (f3)
         3'd0: s = 1;
         3'd1: s = 2;
         3'd2: s = 4;
         3'd4: s = we ? 0 : 1;
         3'd5: s = we ? 0 : 2;
         default: s = 0;
      endcase
      return s;
   endfunction

   function automatic bit ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int s;
      longint last;
      s = access_size(we, f3);
      last = longint'({32'd0, a}) + 3;
      if (s == 0) return 1'b1;
      if ((longint'({32'd0, a}) % s) != 0) return 1'b1;
      if (last >= MEM_BYTES) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      int b;
      longint v;
      b = int'(a[9:0]);
      case (f3)
         3'd0, 3'd4: begin
            v = longint'(model_mem[10'(b)]);
            if (f3 == 3'd0 && v >= 128) v = v - 256;
         end
         3'd1, 3'd5: begin
            v = longint'(model_mem[10'(b)]) + 256 * longint'(model_mem[10'(b + 1)]);
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
         end
         default: begin
            v = longint'(model_mem[10'(b)]) + 256 * longint'(model_mem[10'(b + 1)]) +
                65536 * longint'(model_mem[10'(b + 2)]) +
                16777216 * longint'(model_mem[10'(b + 3)]);
         end
      endcase
      return 32'(v);
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int s;
      s = access_size(1'b1, f3);
      for (int i = 0; i < s; i++) model_mem[10'(int'(a[9:0]) + i)] = 8'((d >> (8 * i)) & 32'hFF);
   endtask

   task automatic set_word(input int a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         mem[10'(a + i)]       = w[8*i +: 8];
         model_mem[10'(a + i)] = w[8*i +: 8];
      end
   endtask

   function automatic logic [31:0] mem_word(input int a);
      return {mem[10'(a + 3)], mem[10'(a + 2)], mem[10'(a + 1)], mem[10'(a)]};
   endfunction

   // driver: one request, returns response and accept-to-resp_valid latency in cycles
   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit noise,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic ready_seen);
      @(negedge clk);
      ready_seen  = req_ready;
      req_valid   = 1'b1;
      req_we      = we;
      req_funct3  = f3;
      req_addr    = a;
      req_wdata   = d;
      ce_cycles   = 0;
      we_cycles   = 0;
      resp_pulses = 0;
      @(posedge clk);
      @(negedge clk);
      lat = 1;
      if (noise) begin
         req_valid  = 1'b1;
         req_we     = 1'($urandom_range(0, 1));
         req_funct3 = 3'($urandom_range(0, 7));
         req_addr   = $urandom_range(0, MEM_BYTES - 1);
         req_wdata  = $urandom;
      end else begin
         req_valid = 1'b0;
      end
      while (!resp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      rdata     = resp_rdata;
      err       = resp_err;
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic exec(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rdata, output logic err,
                       output int lat);
      logic rdy;
      do_op(we, f3, a, d, 1'b0, rdata, err, lat, rdy);
      if (we && !ref_fault(we, f3, a)) ref_store(f3, a, d);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_funct3 = 3'd0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      for (int i = 0; i < MEM_BYTES; i++) begin
         mem[i]       = 8'($urandom_range(0, 255));
         model_mem[i] = mem[i];
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({resp_valid, resp_err, mem_ce, mem_we} !== 4'b0000 || resp_rdata !== 32'd0 ||
          mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%b e=%b ce=%b we=%b rd=%h a=%h wd=%h want all 0",
                  resp_valid, resp_err, mem_ce, mem_we, resp_rdata, mem_addr, mem_wdata);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b want 1", req_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] rd;
      logic err;
      int lat;
      set_word(32'h10, 32'h12345678);
      exec(1'b0, 3'd2, 32'h10, 32'd0, rd, err, lat);
      checks++;
      if (rd !== 32'h12345678 || err !== 1'b0 || lat != 2) begin
         failures++;
         $display("FAIL lw_basic: got rd=%h err=%b lat=%0d want 12345678 0 2", rd, err, lat);
      end
      mem[10'h20] = 8'h80; model_mem[10'h20] = 8'h80;
      mem[10'h21] = 8'hFF; model_mem[10'h21] = 8'hFF;
      exec(1'b0, 3'd0, 32'h20, 32'd0, rd, err, lat);
      checks++;
      if (rd !== 32'hFFFFFF80 || err !== 1'b0) begin
         failures++;
         $display("FAIL lb_sext: got %h err=%b want ffffff80 0", rd, err);
      end
      exec(1'b0, 3'd4, 32'h20, 32'd0, rd, err, lat);
      checks++;
      if (rd !== 32'h00000080 || err !== 1'b0) begin
         failures++;
         $display("FAIL lbu_zext: got %h err=%b want 00000080 0", rd, err);
      end
      exec(1'b0, 3'd1, 32'h20, 32'd0, rd, err, lat);
      checks++;
      if (rd !== 32'hFFFFFF80 || err !== 1'b0) begin
         failures++;
         $display("FAIL lh_sext: got %h err=%b want ffffff80 0", rd, err);
      end
      exec(1'b0, 3'd5, 32'h20, 32'd0, rd, err, lat);
      checks++;
      if (rd !== 32'h0000FF80) begin
         failures++;
         $display("FAIL lhu_zext: got %h want 0000ff80", rd);
      end
      set_word(32'h30, 32'hAABBCCDD);
      exec(1'b1, 3'd0, 32'h30, 32'h00000011, rd, err, lat);
      checks++;
      if (mem_word(32'h30) !== 32'hAABBCC11 || lat != 3 || we_cycles != 1 || rd !== 32'd0) begin
         failures++;
         $display("FAIL sb_rmw: got word=%h lat=%0d we=%0d rd=%h want aabbcc11 3 1 0",
                  mem_word(32'h30), lat, we_cycles, rd);
      end
      exec(1'b1, 3'd1, 32'h30, 32'h00000011, rd, err, lat);
      checks++;
      if (mem_word(32'h30) !== 32'hAABB0011 || lat != 3) begin
         failures++;
         $display("FAIL sh_rmw: got word=%h lat=%0d want aabb0011 3", mem_word(32'h30), lat);
      end
      exec(1'b1, 3'd2, 32'h40, 32'hDEADBEEF, rd, err, lat);
      checks++;
      if (we_cycles != 1 || lat != 2 || err !== 1'b0) begin
         failures++;
         $display("FAIL sw_we_pulse: got we_cycles=%0d lat=%0d err=%b want 1 2 0",
                  we_cycles, lat, err);
      end
      exec(1'b0, 3'd2, 32'h40, 32'd0, rd, err, lat);
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL sw_readback: got %h want deadbeef", rd);
      end
      exec(1'b0, 3'd1, 32'h21, 32'd0, rd, err, lat);
      checks++;
      if (err !== 1'b1 || lat != 1 || ce_cycles != 0 || rd !== 32'd0) begin
         failures++;
         $display("FAIL lh_odd: got err=%b lat=%0d ce=%0d rd=%h want 1 1 0 0", err, lat, ce_cycles, rd);
      end
      exec(1'b0, 3'd2, 32'h22, 32'd0, rd, err, lat);
      checks++;
      if (err !== 1'b1 || lat != 1 || ce_cycles != 0 || rd !== 32'd0) begin
         failures++;
         $display("FAIL lw_misaligned: got err=%b lat=%0d ce=%0d rd=%h want 1 1 0 0", err, lat, ce_cycles, rd);
      end
      exec(1'b0, 3'd2, 32'(MEM_BYTES - 2), 32'd0, rd, err, lat);
      checks++;
      if (err !== 1'b1 || lat != 1 || ce_cycles != 0 || rd !== 32'd0) begin
         failures++;
         $display("FAIL lw_top: got err=%b lat=%0d ce=%0d rd=%h want 1 1 0 0", err, lat, ce_cycles, rd);
      end
      exec(1'b0, 3'd2, 32'(MEM_BYTES - 4), 32'd0, rd, err, lat);
      checks++;
      if (err !== 1'b0 || rd !== ref_load(3'd2, 32'(MEM_BYTES - 4))) begin
         failures++;
         $display("FAIL lw_last_word: got err=%b rd=%h want 0 %h", err, rd, ref_load(3'd2, 32'(MEM_BYTES - 4)));
      end
      exec(1'b1, 3'd0, 32'(MEM_BYTES - 3), 32'h55, rd, err, lat);
      checks++;
      if (err !== 1'b1 || we_cycles != 0 || ce_cycles != 0) begin
         failures++;
         $display("FAIL sb_top_range: got err=%b we=%0d ce=%0d want 1 0 0", err, we_cycles, ce_cycles);
      end
   endtask

   task automatic run_random(input int n, input bit noise, input string name);
      logic [31:0] rd, a, d, exp_rd;
      logic err, we, exp_err, rdy;
      logic [2:0] f3;
      int lat, exp_lat, exp_ce, exp_we, bad;
      logic [2:0] valid_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int k = 0; k < n; k++) begin
         we = 1'($urandom_range(0, 1));
         f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : valid_f3[$urandom_range(0, 4)];
         case ($urandom_range(0, 9))
            0: a = $urandom;
            1: a = 32'(MEM_BYTES - $urandom_range(1, 6));
            default: a = $urandom_range(0, MEM_BYTES - 1);
         endcase
         if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
         d = $urandom;
         exp_err = ref_fault(we, f3, a);
         exp_rd  = (exp_err || we) ? 32'd0 : ref_load(f3, a);
         exp_q.push_back(exp_rd);
         if (exp_err) begin exp_lat = 1; exp_ce = 0; exp_we = 0; end
         else if (!we) begin exp_lat = 2; exp_ce = 1; exp_we = 0; end
         else if (f3 == 3'd2) begin exp_lat = 2; exp_ce = 1; exp_we = 1; end
         else begin exp_lat = 3; exp_ce = 2; exp_we = 1; end
         if (we && !exp_err) ref_store(f3, a, d);
         do_op(we, f3, a, d, noise, rd, err, lat, rdy);
         exp_rd = exp_q.pop_front();
         checks++;
         if (rd !== exp_rd || err !== exp_err) begin
            failures++;
            $display("FAIL %s_resp[%0d]: we=%b f3=%0d a=%h got rd=%h err=%b want rd=%h err=%b",
                     name, k, we, f3, a, rd, err, exp_rd, exp_err);
         end
         checks++;
         if (lat != exp_lat || ce_cycles != exp_ce || we_cycles != exp_we ||
             resp_pulses != 1 || rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s_timing[%0d]: got lat=%0d ce=%0d we=%0d pulses=%0d rdy=%b want %0d %0d %0d 1 1",
                     name, k, lat, ce_cycles, we_cycles, resp_pulses, rdy, exp_lat, exp_ce, exp_we);
         end
      end
      bad = 0;
      for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== model_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s_memory: got %0d differing bytes want 0", name, bad);
      end
   endtask

   task automatic test_random();
      run_random(150, 1'b0, "random");
   endtask

   task automatic test_back_to_back();
      run_random(40, 1'b1, "busy_req");
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd;
      logic err;
      int lat;
      set_word(32'h50, 32'h01020304);
      @(negedge clk);
      resp_pulses = 0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd0;
      req_addr   = 32'h50;
      req_wdata  = 32'h000000AA;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checks++;
      if (mem_ce !== 1'b1 || mem_we !== 1'b0) begin
         failures++;
         $display("FAIL rmw_read_phase: got ce=%b we=%b want 1 0", mem_ce, mem_we);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({resp_valid, resp_err, mem_ce, mem_we} !== 4'b0000 || resp_rdata !== 32'd0 ||
          mem_addr !== 32'd0 || mem_wdata !== 32'd0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset: got v=%b e=%b ce=%b we=%b a=%h rdy=%b want 0 0 0 0 0 1",
                  resp_valid, resp_err, mem_ce, mem_we, mem_addr, req_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (mem_word(32'h50) !== 32'h01020304 || resp_pulses != 0) begin
         failures++;
         $display("FAIL reset_no_commit: got word=%h pulses=%0d want 01020304 0",
                  mem_word(32'h50), resp_pulses);
      end
      exec(1'b0, 3'd2, 32'h50, 32'd0, rd, err, lat);
      checks++;
      if (rd !== 32'h01020304 || err !== 1'b0 || lat != 2) begin
         failures++;
         $display("FAIL after_reset_lw: got rd=%h err=%b lat=%0d want 01020304 0 2", rd, err, lat);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
